// File: rtl/digit_classifier.sv
// 8x8 binary image classifier: scores the image against ten digit templates by Hamming similarity.
// Optional low-score reject (digit 4'hF) when CLASSIFIER_REJECT_EN is defined.
module digit_classifier #(
    parameter logic [639:0] TEMPLATES     = '0,
    parameter logic [6:0]   REJECT_THRESH = 7'd48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] imIn,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit,
    output logic [6:0]  score
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e      state_q;
    logic [63:0] img_q;
    logic [2:0]  row_q;
    logic [3:0]  dig_q;
    logic [6:0]  acc_q;
    logic [6:0]  best_score_q;
    logic [3:0]  best_digit_q;

    logic [9:0]  tmpl_idx;
    logic [7:0]  row_match;
    logic [3:0]  row_score;
    logic [6:0]  tmpl_total;
    logic        new_best;
    logic [6:0]  final_score;
    logic [3:0]  final_digit;
    logic [3:0]  result_digit;

    always_comb begin
        tmpl_idx    = {dig_q, row_q, 3'b000};
        row_match   = ~(img_q[{row_q, 3'b000} +: 8] ^ TEMPLATES[tmpl_idx +: 8]);
        row_score   = '0;
        for (int i = 0; i < 8; i++) begin
            row_score = row_score + {3'b000, row_match[i]};
        end
        tmpl_total  = acc_q + {3'b000, row_score};
        // Strict compare: ties keep the earlier (lower) digit.
        new_best    = tmpl_total > best_score_q;
        final_score = new_best ? tmpl_total : best_score_q;
        final_digit = new_best ? dig_q : best_digit_q;
    end

`ifdef CLASSIFIER_REJECT_EN
    assign result_digit = (final_score < REJECT_THRESH) ? 4'hF : final_digit;
`else
    logic unused_thresh;
    assign unused_thresh = ^REJECT_THRESH;
    assign result_digit  = final_digit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            img_q        <= '0;
            row_q        <= '0;
            dig_q        <= '0;
            acc_q        <= '0;
            best_score_q <= '0;
            best_digit_q <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            digit        <= '0;
            score        <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StFin: begin
                    if (start) begin
                        img_q        <= imIn;
                        row_q        <= '0;
                        dig_q        <= '0;
                        acc_q        <= '0;
                        best_score_q <= '0;
                        best_digit_q <= '0;
                        busy         <= 1'b1;
                        state_q      <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    if (row_q != 3'd7) begin
                        acc_q <= tmpl_total;
                        row_q <= row_q + 3'd1;
                    end else begin
                        acc_q <= '0;
                        row_q <= '0;
                        if (new_best) begin
                            best_score_q <= tmpl_total;
                            best_digit_q <= dig_q;
                        end
                        if (dig_q == 4'd9) begin
                            state_q <= StFin;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            score   <= final_score;
                            digit   <= result_digit;
                        end else begin
                            dig_q <= dig_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_classifier.sv
// Directed self-checking bench for digit_classifier; two instances with different template sets.
module tb_digit_classifier;

    localparam logic [63:0]  Case1 = 64'h00FF_00FF_00FF_00FF;
    localparam logic [63:0]  AllOn = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [639:0] TmplA = 640'(Case1) << 192;
    localparam logic [639:0] TmplB = 640'(64'hFF) << 448;
`ifdef CLASSIFIER_REJECT_EN
    localparam bit RejEn = 1'b1;
`else
    localparam bit RejEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] imIn = '0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [3:0]  digit_a, digit_b;
    logic [6:0]  score_a, score_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_classifier #(.TEMPLATES(TmplA), .REJECT_THRESH(7'd48)) dut_a (
        .clk(clk), .rst(rst), .start(start), .imIn(imIn),
        .busy(busy_a), .done(done_a), .digit(digit_a), .score(score_a)
    );

    digit_classifier #(.TEMPLATES(TmplB), .REJECT_THRESH(7'd48)) dut_b (
        .clk(clk), .rst(rst), .start(start), .imIn(imIn),
        .busy(busy_b), .done(done_b), .digit(digit_b), .score(score_b)
    );

    function automatic logic [3:0] exp_dig(input logic [3:0] d, input logic [6:0] s);
        return (RejEn && s < 7'd48) ? 4'hF : d;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy_a"}, 64'(busy_a), 64'd0);
        check({tag, " done_a"}, 64'(done_a), 64'd0);
        check({tag, " busy_b"}, 64'(busy_b), 64'd0);
        check({tag, " done_b"}, 64'(done_b), 64'd0);
    endtask

    // One classification; imIn is scrambled after the latch and an optional start pulse
    // lands mid-run at cycle `intrude` to prove both are ignored.
    task automatic run_case(input string name, input logic [63:0] img, input int intrude,
                            input logic [3:0] da, input logic [6:0] sa,
                            input logic [3:0] db, input logic [6:0] sb);
        @(negedge clk);
        imIn  = img;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        imIn  = ~img;
        check({name, " busy_a@E0"}, 64'(busy_a), 64'd1);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (cyc == intrude) begin
                start = 1'b1;
                imIn  = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (cyc < 80) begin
                check({name, " busy_a run"}, 64'(busy_a), 64'd1);
                check({name, " done_a run"}, 64'(done_a), 64'd0);
                check({name, " done_b run"}, 64'(done_b), 64'd0);
            end else begin
                check({name, " done_a"}, 64'(done_a), 64'd1);
                check({name, " busy_a fin"}, 64'(busy_a), 64'd0);
                check({name, " digit_a"}, 64'(digit_a), 64'(da));
                check({name, " score_a"}, 64'(score_a), 64'(sa));
                check({name, " done_b"}, 64'(done_b), 64'd1);
                check({name, " digit_b"}, 64'(digit_b), 64'(db));
                check({name, " score_b"}, 64'(score_b), 64'(sb));
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle({name, " after"});
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset digit_a", 64'(digit_a), 64'd0);
        check("reset score_a", 64'(score_a), 64'd0);
        check("reset digit_b", 64'(digit_b), 64'd0);
        check("reset score_b", 64'(score_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Exact match: A -> 3/64; B -> digit 7 scores 40 vs 32 for zero templates
        run_case("exact", Case1, 0, exp_dig(4'd3, 7'd64), 7'd64, exp_dig(4'd7, 7'd40), 7'd40);

        // All-equal tie on zero templates: digit 0 wins
        run_case("tie", 64'd0, 0, 4'd0, 7'd64, 4'd0, 7'd64);

        // Reject case: B scores 8 for digit 7; A scores 32 for digit 3
        run_case("reject", AllOn, 0, exp_dig(4'd3, 7'd32), 7'd32, exp_dig(4'd7, 7'd8), 7'd8);

        // Start while busy is ignored; no second run follows
        run_case("busystart", Case1, 10, exp_dig(4'd3, 7'd64), 7'd64,
                 exp_dig(4'd7, 7'd40), 7'd40);
        for (int i = 0; i < 90; i++) begin
            @(posedge clk);
            #1;
            check("busystart no rerun done_a", 64'(done_a), 64'd0);
            check("busystart no rerun busy_a", 64'(busy_a), 64'd0);
        end

        // Reset mid-run aborts without a done pulse and clears the outputs
        @(negedge clk);
        imIn  = Case1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("midreset");
        check("midreset digit_a", 64'(digit_a), 64'd0);
        check("midreset score_a", 64'(score_a), 64'd0);
        check("midreset digit_b", 64'(digit_b), 64'd0);
        check("midreset score_b", 64'(score_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            check("midreset no done_a", 64'(done_a), 64'd0);
        end
        run_case("postreset", Case1, 0, exp_dig(4'd3, 7'd64), 7'd64,
                 exp_dig(4'd7, 7'd40), 7'd40);

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        imIn  = Case1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check_idle("rst+start");
        @(posedge clk);
        #1;
        check_idle("rst+start next");

        // Back-to-back: start held high gives done every 81 cycles
        @(negedge clk);
        imIn  = Case1;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 242; cyc++) begin
            @(posedge clk);
            #1;
            check("b2b done_a", 64'(done_a), 64'(cyc % 81 == 80));
            check("b2b busy_a", 64'(busy_a), 64'(cyc % 81 != 80));
            if (cyc % 81 == 80) begin
                check("b2b digit_a", 64'(digit_a), 64'(exp_dig(4'd3, 7'd64)));
                check("b2b score_a", 64'(score_a), 64'd64);
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("b2b end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
